// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dm_arb_pkg;

  localparam int WORD_BYTES     = 4;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } dm_state_e;

  // DMA bursts are word-granular: drop the byte offset of the start address.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// CPU, DMA and data-memory port bundle of the arbiter.
// slave: arbiter side; master: surrounding CPU/DMA/DM environment.
interface dm_arbiter_if;

  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wd;
  logic [31:0] cpu_pc;
  logic [31:0] cpu_rd;
  logic        cpu_stall;

  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [3:0]  dma_len;
  logic [31:0] dma_wd;
  logic        dma_gnt;
  logic        dma_beat;
  logic [31:0] dma_rd;
  logic        dma_rvalid;
  logic        dma_done;

  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic [31:0] dm_pc;
  logic [31:0] dm_rd;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wd, cpu_pc,
    output cpu_rd, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_len, dma_wd,
    output dma_gnt, dma_beat, dma_rd, dma_rvalid, dma_done,
    output dm_we, dm_addr, dm_wd, dm_pc,
    input  dm_rd
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wd, cpu_pc,
    input  cpu_rd, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_len, dma_wd,
    input  dma_gnt, dma_beat, dma_rd, dma_rvalid, dma_done,
    input  dm_we, dm_addr, dm_wd, dm_pc,
    output dm_rd
  );

endinterface

// File: rtl/dm_arb_starve.sv
// DMA starvation guard: counts consecutive cycles a DMA beat waits behind
// the CPU and forces a beat once the count reaches STARVE_MAX.
module dm_arb_starve
  import dm_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic pend_i,
  input  logic beat_i,
  output logic force_o
);

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] MAX_C = CW'(STARVE_MAX);

  logic [CW-1:0] cnt_q;

  // Count denied pending cycles; any DMA beat restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (beat_i) begin
      cnt_q <= '0;
    end else if (pend_i && (cnt_q != MAX_C)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign force_o = pend_i && (cnt_q == MAX_C);

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory arbiter between the CPU M-stage and a burst DMA engine.
// The CPU wins by default; DM_ARB_STARVE_EN adds a starvation guard that
// forces a DMA beat after STARVE_MAX consecutive denied cycles.
//
// state | meaning
// IDLE  | no burst in flight; a pending command may be accepted (beat 0)
// BURST | beats 1..len of an accepted command remain
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input logic         clk,
  input logic         reset,
  dm_arbiter_if.slave bus
);

  dm_state_e   state_q;
  logic [31:0] addr_q;
  logic        we_q;
  logic [3:0]  left_q;
  logic [31:0] rd_q;
  logic        rvalid_q;
  logic        done_q;

  logic        pend;
  logic        force_beat;
  logic        beat;
  logic        cpu_srv;
  logic        cur_we;
  logic        last_beat;
  logic [31:0] cur_addr;

  // Reset gates every request so nothing touches DM while reset is held.
  assign pend      = reset && (((state_q == IDLE) && bus.dma_req) || (state_q == BURST));
  assign beat      = pend && (!bus.cpu_req || force_beat);
  assign cpu_srv   = reset && bus.cpu_req && !beat;
  assign cur_addr  = (state_q == IDLE) ? word_align(bus.dma_addr) : addr_q;
  assign cur_we    = (state_q == IDLE) ? bus.dma_we : we_q;
  assign last_beat = (state_q == IDLE) ? (bus.dma_len == 4'd0) : (left_q == 4'd1);

`ifdef DM_ARB_STARVE_EN
  dm_arb_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .pend_i  (pend),
    .beat_i  (beat),
    .force_o (force_beat)
  );
`else
  logic [31:0] unused_starve_max;
  assign unused_starve_max = 32'(STARVE_MAX);
  assign force_beat        = 1'b0;
`endif

  assign bus.dma_gnt    = beat && (state_q == IDLE);
  assign bus.dma_beat   = beat;
  assign bus.cpu_stall  = bus.cpu_req && beat;
  assign bus.cpu_rd     = bus.dm_rd;
  assign bus.dm_addr    = beat ? cur_addr : bus.cpu_addr;
  assign bus.dm_we      = beat ? cur_we : (cpu_srv && bus.cpu_we);
  assign bus.dm_wd      = beat ? bus.dma_wd : bus.cpu_wd;
  assign bus.dm_pc      = beat ? 32'h0 : bus.cpu_pc;
  assign bus.dma_rd     = rd_q;
  assign bus.dma_rvalid = rvalid_q;
  assign bus.dma_done   = done_q;

  // Burst sequencing: latch the command on accept, then walk the address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      left_q  <= '0;
    end else if (beat) begin
      addr_q <= cur_addr + 32'(WORD_BYTES);
      we_q   <= cur_we;
      if (last_beat) begin
        state_q <= IDLE;
        left_q  <= '0;
      end else begin
        state_q <= BURST;
        left_q  <= (state_q == IDLE) ? bus.dma_len : left_q - 4'd1;
      end
    end
  end

  // Read-data return and completion pulse, one cycle after the beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q     <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rvalid_q <= beat && !cur_we;
      done_q   <= beat && last_beat;
      if (beat && !cur_we) begin
        rd_q <= bus.dm_rd;
      end
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: a per-cycle transaction model predicts
// beats, CPU services, stalls, read returns and done pulses into queues; a
// negedge monitor pops and compares whenever the DUT presents an event.
module tb_dm_arbiter;
  import dm_arb_pkg::*;

  localparam int SMAX = STARVE_MAX_DEF;
`ifdef DM_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dm_arbiter_if ifc();

  dm_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Data memory behind the arbiter (aliased onto 1024 words)
  logic [31:0] dm_mem  [1024];
  logic [31:0] ref_mem [1024];

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE0000 ^ (32'(i) * 32'h01000193);
  endfunction

  function automatic logic [31:0] wd_of(input int unsigned c);
    return 32'hD0000000 ^ (c * 32'h9E3779B1);
  endfunction

  initial for (int i = 0; i < 1024; i++) dm_mem[i] <= pat(i);
  assign ifc.dm_rd = dm_mem[ifc.dm_addr[11:2]];
  always @(posedge clk) if (ifc.dm_we) dm_mem[ifc.dm_addr[11:2]] <= ifc.dm_wd;

  typedef struct { int unsigned c; logic [31:0] a; logic we; logic [31:0] wd; logic gnt; } beat_t;
  typedef struct { int unsigned c; logic [31:0] a; logic we; logic [31:0] wd; logic [31:0] pc; logic [31:0] rd; } cpu_t;
  typedef struct { int unsigned c; logic [31:0] d; } rsp_t;

  beat_t       beat_q[$];
  cpu_t        cpu_q[$];
  rsp_t        rd_q[$];
  int unsigned done_q[$];
  int unsigned stall_q[$];

  // Transaction-level model of the DMA command in flight
  bit          act = 1'b0;
  bit          first = 1'b0;
  logic [31:0] m_addr;
  logic        m_we;
  int          m_left;
  int          denied;

  task automatic step(input bit creq, input bit start, input logic [31:0] a,
                      input logic [3:0] l, input bit w);
    logic [31:0] ca;
    bit          issue;
    int          idx;
    @(posedge clk);
    #1;
    ca = {20'h0, 12'($urandom)};
    ifc.cpu_req  = creq;
    ifc.cpu_we   = 1'($urandom_range(0, 1));
    ifc.cpu_addr = ca;
    ifc.cpu_wd   = $urandom;
    ifc.cpu_pc   = $urandom | 32'h1000;
    ifc.dma_wd   = wd_of(cyc);
    if (start && !act) begin
      act = 1'b1; first = 1'b1;
      m_addr = {a[31:2], 2'b00}; m_we = w; m_left = int'(l) + 1; denied = 0;
      ifc.dma_req = 1'b1; ifc.dma_addr = a; ifc.dma_len = l; ifc.dma_we = w;
    end else if (!first) begin
      ifc.dma_req  = 1'b0;
      ifc.dma_addr = $urandom;
      ifc.dma_len  = 4'($urandom);
      ifc.dma_we   = 1'($urandom_range(0, 1));
    end
    issue = 1'b0;
    if (act) begin
      issue = !creq || (STARVE_EN && denied >= SMAX);
      if (issue) begin
        idx = int'(m_addr[11:2]);
        beat_q.push_back('{cyc, m_addr, m_we, ifc.dma_wd, first});
        if (m_we) ref_mem[idx] = ifc.dma_wd;
        else rd_q.push_back('{cyc + 1, ref_mem[idx]});
        m_addr = m_addr + 32'd4;
        m_left--; denied = 0; first = 1'b0;
        if (m_left == 0) begin
          act = 1'b0;
          done_q.push_back(cyc + 1);
        end
      end else begin
        denied++;
      end
    end
    if (creq && issue) stall_q.push_back(cyc);
    if (creq && !issue) begin
      idx = int'(ca[11:2]);
      cpu_q.push_back('{cyc, ca, ifc.cpu_we, ifc.cpu_wd, ifc.cpu_pc, ref_mem[idx]});
      if (ifc.cpu_we) ref_mem[idx] = ifc.cpu_wd;
    end
  endtask

  // Monitor: compare every DUT event against the head of its queue
  always @(negedge clk) begin : monitor
    beat_t eb;
    cpu_t  ec;
    rsp_t  er;
    int unsigned ed;
    if (reset && mon_en) begin
      if (!ifc.dma_beat) check32("dma_gnt without beat", 32'(ifc.dma_gnt), 32'h0);
      if (!ifc.cpu_req && !ifc.dma_beat) check32("dm_we no master", 32'(ifc.dm_we), 32'h0);
      if (ifc.dma_beat) begin
        if (beat_q.size() == 0) check32("dma_beat unexpected", 32'(ifc.dma_beat), 32'h0);
        else begin
          eb = beat_q.pop_front();
          check32("beat cycle", cyc, eb.c);
          check32("beat dm_addr", ifc.dm_addr, eb.a);
          check32("beat dm_we", 32'(ifc.dm_we), 32'(eb.we));
          check32("beat dm_wd", ifc.dm_wd, eb.wd);
          check32("beat dm_pc", ifc.dm_pc, 32'h0);
          check32("beat dma_gnt", 32'(ifc.dma_gnt), 32'(eb.gnt));
        end
      end
      if (ifc.cpu_stall) begin
        if (stall_q.size() == 0) check32("cpu_stall unexpected", 32'(ifc.cpu_stall), 32'h0);
        else check32("stall cycle", cyc, stall_q.pop_front());
      end
      if (ifc.cpu_req && !ifc.cpu_stall) begin
        if (cpu_q.size() == 0) check32("cpu_stall missing", 32'(ifc.cpu_stall), 32'h1);
        else begin
          ec = cpu_q.pop_front();
          check32("cpu cycle", cyc, ec.c);
          check32("cpu dm_addr", ifc.dm_addr, ec.a);
          check32("cpu dm_we", 32'(ifc.dm_we), 32'(ec.we));
          check32("cpu dm_pc", ifc.dm_pc, ec.pc);
          if (ec.we) check32("cpu dm_wd", ifc.dm_wd, ec.wd);
          else check32("cpu_rd", ifc.cpu_rd, ec.rd);
        end
      end
      if (ifc.dma_rvalid) begin
        if (rd_q.size() == 0) check32("dma_rvalid unexpected", 32'(ifc.dma_rvalid), 32'h0);
        else begin
          er = rd_q.pop_front();
          check32("rvalid cycle", cyc, er.c);
          check32("dma_rd", ifc.dma_rd, er.d);
        end
      end
      if (ifc.dma_done) begin
        if (done_q.size() == 0) check32("dma_done unexpected", 32'(ifc.dma_done), 32'h0);
        else begin
          ed = done_q.pop_front();
          check32("done cycle", cyc, ed);
        end
      end
    end
  end

  task automatic check_quiet(input string tag);
    check32({tag, " dm_we"}, 32'(ifc.dm_we), 32'h0);
    check32({tag, " dma_gnt"}, 32'(ifc.dma_gnt), 32'h0);
    check32({tag, " dma_beat"}, 32'(ifc.dma_beat), 32'h0);
    check32({tag, " dma_done"}, 32'(ifc.dma_done), 32'h0);
    check32({tag, " dma_rvalid"}, 32'(ifc.dma_rvalid), 32'h0);
    check32({tag, " cpu_stall"}, 32'(ifc.cpu_stall), 32'h0);
    check32({tag, " dma_rd"}, ifc.dma_rd, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
    ifc.cpu_req = 1'b0; ifc.cpu_we = 1'b0; ifc.cpu_addr = '0; ifc.cpu_wd = '0; ifc.cpu_pc = '0;
    ifc.dma_req = 1'b1; ifc.dma_we = 1'b1; ifc.dma_addr = 32'h80; ifc.dma_len = 4'd2; ifc.dma_wd = '0;

    // Reset state, with a DMA request already presented
    repeat (2) @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    ifc.dma_req = 1'b0;
    reset = 1'b1;
    mon_en = 1'b1;

    // Idle CPU, 4-beat write at 0x100
    step(1'b0, 1'b1, 32'h100, 4'd3, 1'b1);
    repeat (5) step(1'b0, 1'b0, '0, '0, 1'b0);

    // Single-beat read from unaligned 0x203, then read back the burst
    step(1'b0, 1'b1, 32'h203, 4'd0, 1'b0);
    step(1'b0, 1'b1, 32'h100, 4'd3, 1'b0);
    repeat (6) step(1'b0, 1'b0, '0, '0, 1'b0);

    // Address wrap past 0xFFFFFFFC, written then read back
    step(1'b0, 1'b1, 32'hFFFFFFF8, 4'd2, 1'b1);
    repeat (3) step(1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b0, 1'b1, 32'hFFFFFFF8, 4'd2, 1'b0);
    repeat (4) step(1'b0, 1'b0, '0, '0, 1'b0);

    // CPU holds the port while a 2-beat read waits
    step(1'b1, 1'b1, 32'h300, 4'd1, 1'b0);
    repeat (14) step(1'b1, 1'b0, '0, '0, 1'b0);
    repeat (4) step(1'b0, 1'b0, '0, '0, 1'b0);

    // Reset after beat 1 of a 4-beat write aborts the burst
    step(1'b0, 1'b1, 32'h040, 4'd3, 1'b1);
    step(1'b0, 1'b0, '0, '0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    ifc.dma_req = 1'b1; ifc.dma_we = 1'b1; ifc.cpu_req = 1'b0;
    act = 1'b0; first = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_quiet("mid-burst reset");
    end
    @(posedge clk); #1;
    ifc.dma_req = 1'b0;
    reset = 1'b1;
    // Beats 2 and 3 never landed, and a new command is granted at once
    step(1'b0, 1'b1, 32'h048, 4'd1, 1'b0);
    repeat (3) step(1'b0, 1'b0, '0, '0, 1'b0);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      logic [31:0] ra;
      ra = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFE0 | 32'($urandom_range(0, 31))) : $urandom;
      step(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 35), ra,
           4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    // Drain, bounded
    for (int k = 0; k < 64 && act; k++) step(1'b0, 1'b0, '0, '0, 1'b0);
    repeat (3) step(1'b0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    check32("pending beats left", 32'(beat_q.size()), 32'h0);
    check32("pending cpu accesses left", 32'(cpu_q.size()), 32'h0);
    check32("pending read returns left", 32'(rd_q.size()), 32'h0);
    check32("pending done pulses left", 32'(done_q.size()), 32'h0);
    check32("pending stalls left", 32'(stall_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive denied DMA cycles before a forced DMA beat.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  M-stage data-memory access this cycle.
- cpu_we  in  1  M-stage write.
- cpu_addr  in  32  byte address.
- cpu_wd  in  32  write data.
- cpu_pc  in  32  PC of the M-stage instruction.
- cpu_rd  out  32  read data; equals dm_rd.
- cpu_stall  out  1  CPU access not served this cycle; freeze M and upstream stages.
- dma_req  in  1  burst command pending.
- dma_we  in  1  burst is a write.
- dma_addr  in  32  burst start address.
- dma_len  in  4  beat count minus 1.
- dma_wd  in  32  write data for the current beat.
- dma_gnt  out  1  pulse: command accepted (first beat issued).
- dma_beat  out  1  a DMA beat drives DM this cycle; dma_wd consumed.
- dma_rd  out  32  registered read data.
- dma_rvalid  out  1  dma_rd valid; one cycle after each read beat.
- dma_done  out  1  pulse: cycle after the final beat.
- dm_we, dm_addr, dm_wd, dm_pc  out  1/32/32/32  DM port drive.
- dm_rd  in  32  DM combinational read data.

Function
REQ-003 SHALL serve exactly one master per cycle; DM reads are combinational and writes commit on the clock edge.
REQ-004 SHALL use FSM states IDLE and BURST.
REQ-005 IDLE->BURST on accept when dma_len>0; IDLE->IDLE on accept when dma_len=0; BURST->IDLE after the last beat.
REQ-006 SHALL give the CPU priority by default; a DMA beat issues only when cpu_req=0, or when a forced beat is due (REQ-011).
REQ-007 SHALL accept a command in IDLE when dma_req=1 and a DMA beat issues.
- The accept cycle is beat 0.
- dma_gnt=1 for that one cycle.
- Command fields SHALL be held until dma_gnt.
REQ-008 SHALL latch dma_we and dma_len at accept, and dma_addr with bits [1:0] forced to 0.
- The address increments by 4 per beat and wraps from 0xFFFFFFFC to 0x00000000.
REQ-009 DMA beats SHALL drive dm_pc=0 and dm_wd=dma_wd; CPU accesses SHALL drive dm_pc=cpu_pc.
- When no master is served, dm_we SHALL be 0.
REQ-010 cpu_stall SHALL be combinational: 1 exactly when cpu_req=1 and a DMA beat issues.
REQ-011 With starvation enabled:
- Counter increments each cycle a DMA beat is pending (IDLE with dma_req, or BURST) but not served.
- When the counter equals STARVE_MAX, the next pending DMA beat issues regardless of cpu_req.
- Counter clears on any DMA beat.
REQ-012 SHALL register dma_rd<=dm_rd and pulse dma_rvalid the cycle after each read beat; write beats produce no rvalid.
REQ-013 SHALL pulse dma_done one cycle after the final beat, including single-beat commands.
- A new command SHALL be accepted no earlier than the dma_done cycle.

Reset
REQ-014 On reset=0:
- State IDLE; counter, beat count and latched address cleared.
- dma_gnt, dma_beat, dma_rvalid, dma_done, dm_we, cpu_stall = 0; dma_rd = 0.
REQ-015 Reset mid-burst SHALL abort the burst: no dma_done, and no DM write after reset asserts.

Configuration
REQ-016 With DM_ARB_STARVE_EN defined: REQ-011 applies.
- Without it: no counter is built, the CPU always wins, and DMA may starve indefinitely.

Structure
REQ-017 Package dm_arb_pkg SHALL hold the FSM state enum, the WORD_BYTES=4 constant and the default STARVE_MAX.
REQ-018 Sub-module dm_arb_starve SHALL hold the starvation counter and force logic, instantiated only under DM_ARB_STARVE_EN.

Verification
REQ-019 The bench SHALL cover these scenarios:
- Idle CPU, DMA write addr=0x100, len=3 -> beats at 0x100/104/108/10C on 4 consecutive cycles; dma_gnt on cycle 0; dma_done on cycle 4.
- DMA read addr=0x203, len=0 -> dm_addr=0x200; dma_rvalid with dma_rd=DM[0x200] next cycle; dma_done the same cycle.
- cpu_req held 1, DMA pending, STARVE_MAX=4, macro defined -> forced beat on the 5th pending cycle with cpu_stall=1 that cycle only.
- Same stimulus, macro undefined -> no DMA beat and cpu_stall=0 throughout.
- Burst from 0xFFFFFFF8, len=2 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- reset=0 after beat 1 of a 4-beat write -> no further dm_we, no dma_done; FSM in IDLE.
